video_timing_sequencer: RTL

- Sequences horizontal and vertical raster position and emits blank, sync, data-enable and pixel coordinates for the video output path.
- Each axis is a four-segment state machine: active, front porch, sync, back porch.
- Segment lengths are runtime-configurable through shadow registers. Committed values take effect only at a frame boundary, so a mode change never produces a torn frame.

---
 rtl/video_timing_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/video_timing_sequencer.sv
// video_timing_sequencer: raster timing generator with frame-boundary reconfiguration
module video_timing_sequencer #(
  parameter int C = 10,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [C-1:0] cfg_wdata,
  input  logic         cfg_commit,
  output logic         cfg_pending,
  output logic         hsync,
  output logic         vsync,
  output logic         hblank,
  output logic         vblank,
  output logic         de,
  output logic [C-1:0] x,
  output logic [C-1:0] y,
  output logic         line_start,
  output logic         frame_start
);
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} seg_t;

  localparam logic [C-1:0] DEF [8] = '{C'(H_ACT), C'(H_FP), C'(H_SYNC), C'(H_BP),
                                        C'(V_ACT), C'(V_FP), C'(V_SYNC), C'(V_BP)};

  logic [C-1:0] cur [8];
  logic [C-1:0] shd [8];
  seg_t h_st, h_st_n, v_st, v_st_n;
  logic [C-1:0] h_cnt, h_cnt_n, v_cnt, v_cnt_n, h_len, v_len;
  logic h_last, v_last, line_end, frame_end;

  // Active and sync segments never shorter than one unit; porches may be zero
  function automatic logic [C-1:0] seg_len(input seg_t s, input logic [C-1:0] a, f, sy, b);
    return s == ACT ? (a == '0 ? C'(1) : a) : s == FP ? f : s == SYNC ? (sy == '0 ? C'(1) : sy) : b;
  endfunction

  // Zero-length porches are skipped entirely
  function automatic seg_t seg_next(input seg_t s, input logic [C-1:0] f, b);
    return s == ACT ? (f == '0 ? SYNC : FP) : s == FP ? SYNC : s == SYNC ? (b == '0 ? ACT : BP) : ACT;
  endfunction

  // Next raster position; vertical axis steps only at end of line
  always_comb begin
    h_len = seg_len(h_st, cur[0], cur[1], cur[2], cur[3]);
    v_len = seg_len(v_st, cur[4], cur[5], cur[6], cur[7]);
    h_last = h_cnt == h_len - C'(1);
    v_last = v_cnt == v_len - C'(1);
    h_st_n = h_last ? seg_next(h_st, cur[1], cur[3]) : h_st;
    h_cnt_n = h_last ? '0 : h_cnt + C'(1);
    line_end = h_last && h_st_n == ACT;
    v_st_n = line_end && v_last ? seg_next(v_st, cur[5], cur[7]) : v_st;
    v_cnt_n = line_end ? (v_last ? '0 : v_cnt + C'(1)) : v_cnt;
    frame_end = line_end && v_last && v_st_n == ACT;
  end

  // Position state, advanced once per enabled pixel clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_st <= ACT;
      v_st <= ACT;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      h_st <= h_st_n;
      v_st <= v_st_n;
      h_cnt <= h_cnt_n;
      v_cnt <= v_cnt_n;
    end
  end

  // Shadow writes any time; committed lengths swap in only on the frame wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= DEF;
      shd <= DEF;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_we) shd[cfg_addr] <= cfg_wdata;
      if (enable && frame_end && cfg_pending) cur <= shd;
      cfg_pending <= cfg_commit | (cfg_pending & ~(enable & frame_end));
    end
  end

  // Registered outputs describe the pixel being left on this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= SYNC_ACTIVE_LOW;
      vsync <= SYNC_ACTIVE_LOW;
      hblank <= 1'b0;
      vblank <= 1'b0;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hsync <= (h_st == SYNC) ^ SYNC_ACTIVE_LOW;
      vsync <= (v_st == SYNC) ^ SYNC_ACTIVE_LOW;
      hblank <= h_st != ACT;
      vblank <= v_st != ACT;
      de <= h_st == ACT && v_st == ACT;
      x <= h_st == ACT ? h_cnt : '0;
      y <= v_st == ACT ? v_cnt : '0;
      line_start <= h_st == ACT && h_cnt == '0;
      frame_start <= h_st == ACT && h_cnt == '0 && v_st == ACT && v_cnt == '0;
    end else begin
      de <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule
